// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : 800x600 @ 60 Hz VGA timing generator (40 MHz pixel clock).
//                Produces horizontal/vertical counters, sync and blanking
//                flags, a one-cycle frame_start pulse at (0,0) and an
//                optional completed-frame counter.
//  Options     : VGA_TIMING_FRAME_CNT_EN - when defined, frame_cnt counts
//                completed frames (mod 65536); otherwise it is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    // ------------------------------------------------------------------------
    // Timing constants (counter values, inclusive ranges)
    // ------------------------------------------------------------------------
    // Horizontal: 800 visible + 40 front porch + 128 sync + 88 back porch
    localparam logic [11:0] H_VISIBLE    = 12'd800;
    localparam logic [11:0] H_SYNC_FIRST = 12'd840;
    localparam logic [11:0] H_SYNC_LAST  = 12'd967;
    localparam logic [11:0] H_LAST       = 12'd1055;

    // Vertical: 600 visible + 1 front porch + 4 sync + 23 back porch
    localparam logic [11:0] V_VISIBLE    = 12'd600;
    localparam logic [11:0] V_SYNC_FIRST = 12'd601;
    localparam logic [11:0] V_SYNC_LAST  = 12'd604;
    localparam logic [11:0] V_LAST       = 12'd627;

    // ------------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------------
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_wrap;
    logic [11:0] w_hcount_nxt;
    logic [11:0] w_vcount_nxt;
    logic        w_hblnk_nxt;
    logic        w_hsync_nxt;
    logic        w_vblnk_nxt;
    logic        w_vsync_nxt;

    // End-of-line / end-of-frame detection on the current (registered) counts
    assign w_h_last     = (hcount_out == H_LAST);
    assign w_v_last     = (vcount_out == V_LAST);
    assign w_frame_wrap = w_h_last & w_v_last;

    // Horizontal counter wraps 1055 -> 0
    assign w_hcount_nxt = w_h_last ? 12'd0 : (hcount_out + 12'd1);

    // Vertical counter only moves on the horizontal wrap, and wraps 627 -> 0
    // on that same edge
    assign w_vcount_nxt = !w_h_last ? vcount_out
                        : (w_v_last ? 12'd0 : (vcount_out + 12'd1));

    // Flags are decoded from the next-state counts so that, once registered,
    // they line up exactly with the counts presented in the same cycle
    assign w_hblnk_nxt = (w_hcount_nxt >= H_VISIBLE);
    assign w_hsync_nxt = (w_hcount_nxt >= H_SYNC_FIRST) &&
                         (w_hcount_nxt <= H_SYNC_LAST);
    assign w_vblnk_nxt = (w_vcount_nxt >= V_VISIBLE);
    assign w_vsync_nxt = (w_vcount_nxt >= V_SYNC_FIRST) &&
                         (w_vcount_nxt <= V_SYNC_LAST);

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------

    // Pixel/line counters: advance only while enabled, reset has priority
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
        end else if (en) begin
            hcount_out <= w_hcount_nxt;
            vcount_out <= w_vcount_nxt;
        end
    end

    // Sync and blanking flags: register the next-state decode alongside counts
    always_ff @(posedge pclk) begin
        if (rst) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            hblnk_out <= 1'b0;
            vblnk_out <= 1'b0;
        end else if (en) begin
            hsync_out <= w_hsync_nxt;
            vsync_out <= w_vsync_nxt;
            hblnk_out <= w_hblnk_nxt;
            vblnk_out <= w_vblnk_nxt;
        end
    end

    // Frame start pulse: only on an enabled edge that performs (1055,627)->(0,0);
    // reset release starts at (0,0) without a wrap, so it never pulses there
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else if (en) begin
            frame_start <= w_frame_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Optional completed-frame counter
    // ------------------------------------------------------------------------
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] w_frame_cnt_nxt;

    // Increments on exactly the edges that raise frame_start; wraps naturally
    assign w_frame_cnt_nxt = (en && w_frame_wrap) ? (frame_cnt + 16'd1)
                                                  : frame_cnt;

    // Frame counter register
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else begin
            frame_cnt <= w_frame_cnt_nxt;
        end
    end
`else
    // Feature disabled: constant output, no storage
    assign frame_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Self-checking bench for vga_timing. Directed vector table for
//                reset and the first line, plus hand-written sequences for
//                enable hold, vertical blanking/sync over a frame wrap, wrap
//                with en low, and mid-frame reset. Long stretches of the frame
//                are skipped by forcing the next-state counter nets for one
//                edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic        pclk;
    logic        rst;
    logic        en;
    logic [11:0] hcount_out;
    logic [11:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [11:0] jump_h;
    logic [11:0] jump_v;
    logic [15:0] jump_fc;

    vga_timing dut (
        .pclk        (pclk),
        .rst         (rst),
        .en          (en),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // 40 MHz pixel clock
    initial pclk = 1'b0;
    always #12.5 pclk = ~pclk;

    typedef struct {
        logic        rst;
        logic        en;
        int          cycles;
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int h, input int v,
                           input int hs, input int vs, input int hb,
                           input int vb, input int fs, input int fc);
        chk({tag, ".hcount"},      hcount_out,  h);
        chk({tag, ".vcount"},      vcount_out,  v);
        chk({tag, ".hsync"},       hsync_out,   hs);
        chk({tag, ".vsync"},       vsync_out,   vs);
        chk({tag, ".hblnk"},       hblnk_out,   hb);
        chk({tag, ".vblnk"},       vblnk_out,   vb);
        chk({tag, ".frame_start"}, frame_start, fs);
        chk({tag, ".frame_cnt"},   frame_cnt,   fc);
    endtask

    // Load the counters with (jump_h, jump_v) on one enabled edge; flags are
    // decoded by the DUT from the same forced next-state values
    task jump;
        rst = 1'b0;
        en  = 1'b1;
        force dut.w_hcount_nxt = jump_h;
        force dut.w_vcount_nxt = jump_v;
`ifdef VGA_TIMING_FRAME_CNT_EN
        force dut.w_frame_cnt_nxt = jump_fc;
`endif
        @(negedge pclk);
        release dut.w_hcount_nxt;
        release dut.w_vcount_nxt;
`ifdef VGA_TIMING_FRAME_CNT_EN
        release dut.w_frame_cnt_nxt;
`endif
    endtask

    initial begin
        int exp_h;
        int exp_v;
        int bad_pos;
        int bad_flag;
        int vs_cnt;
        int vb_cnt;
        int fs_cnt;
        int fs_step;
        int fc_exp;

        // {rst, en, cycles, h, v, hs, vs, hb, vb, fs}
        vecs[0]  = '{1'b1, 1'b1,   3, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1,   1, 12'd1,    12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 798, 12'd799,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1,   1, 12'd800,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1,  39, 12'd839,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1,   1, 12'd840,  12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 127, 12'd967,  12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1,   1, 12'd968,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1,  87, 12'd1055, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1,   1, 12'd0,    12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0,   5, 12'd0,    12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1,   1, 12'd1,    12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        en      = 1'b0;
        jump_h  = 12'd0;
        jump_v  = 12'd0;
        jump_fc = 16'd0;
        @(negedge pclk);

        // ---------------- Table: reset and first line ----------------
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            repeat (vecs[i].cycles) @(negedge pclk);
            chk_all($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].hs,
                    vecs[i].vs, vecs[i].hb, vecs[i].vb, vecs[i].fs, 0);
        end

        // ---------------- Enable low holds everything ----------------
        jump_h = 12'd500; jump_v = 12'd10; jump_fc = 16'd0;
        jump;
        chk_all("hold.entry", 500, 10, 0, 0, 0, 0, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            chk($sformatf("hold%0d.hcount", i), hcount_out, 500);
            chk($sformatf("hold%0d.vcount", i), vcount_out, 10);
            chk($sformatf("hold%0d.frame_start", i), frame_start, 0);
        end
        en = 1'b1;
        @(negedge pclk);
        chk_all("hold.resume", 501, 10, 0, 0, 0, 0, 0, 0);

        // ---------------- Vertical blanking/sync across a frame wrap ----------------
        jump_h = 12'd1050; jump_v = 12'd596; jump_fc = 16'hFFFF;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = 65535;
`else
        fc_exp = 0;
`endif
        jump;
        chk_all("frame.entry", 1050, 596, 0, 0, 1, 0, 0, fc_exp);
        exp_h = 1050; exp_v = 596;
        bad_pos = 0; bad_flag = 0; vs_cnt = 0; vb_cnt = 0; fs_cnt = 0; fs_step = -1;
        for (int s = 1; s <= 33798; s++) begin
            @(negedge pclk);
            if (exp_h == 1055) begin
                exp_h = 0;
                exp_v = (exp_v == 627) ? 0 : exp_v + 1;
            end else begin
                exp_h = exp_h + 1;
            end
            if (hcount_out !== 12'(exp_h) || vcount_out !== 12'(exp_v)) bad_pos++;
            if (hblnk_out !== (exp_h >= 800) ||
                hsync_out !== (exp_h >= 840 && exp_h <= 967) ||
                vblnk_out !== (exp_v >= 600) ||
                vsync_out !== (exp_v >= 601 && exp_v <= 604) ||
                frame_start !== (exp_h == 0 && exp_v == 0)) bad_flag++;
            if (vsync_out === 1'b1) vs_cnt++;
            if (vblnk_out === 1'b1) vb_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_step = s;
            end
        end
        chk("frame.position_errors", bad_pos, 0);
        chk("frame.flag_errors", bad_flag, 0);
        chk("frame.vsync_cycles", vs_cnt, 4224);
        chk("frame.vblnk_cycles", vb_cnt, 29568);
        chk("frame.start_pulses", fs_cnt, 1);
        chk("frame.start_step", fs_step, 32742);
        chk("frame.cnt_after_wrap", frame_cnt, 0);

        // ---------------- en low on the wrap cycle ----------------
        jump_h = 12'd1055; jump_v = 12'd627; jump_fc = 16'd0;
        jump;
        chk_all("wrapen.entry", 1055, 627, 0, 0, 1, 1, 0, 0);
        en = 1'b0;
        repeat (3) @(negedge pclk);
        chk_all("wrapen.held", 1055, 627, 0, 0, 1, 1, 0, 0);
        en = 1'b1;
        @(negedge pclk);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = 1;
`else
        fc_exp = 0;
`endif
        chk_all("wrapen.wrap", 0, 0, 0, 0, 0, 0, 1, fc_exp);
        @(negedge pclk);
        chk_all("wrapen.after", 1, 0, 0, 0, 0, 0, 0, fc_exp);

        // ---------------- Mid-frame reset ----------------
        jump_h = 12'd900; jump_v = 12'd300; jump_fc = 16'd0;
        jump;
        chk_all("midrst.entry", 900, 300, 1, 0, 1, 0, 0, 0);
        rst = 1'b1;
        @(negedge pclk);
        chk_all("midrst.reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge pclk);
        chk_all("midrst.release", 1, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- Reset beats a wrap on the same edge ----------------
        jump_h = 12'd1055; jump_v = 12'd627; jump_fc = 16'd0;
        jump;
        rst = 1'b1;
        @(negedge pclk);
        chk_all("rstwrap.reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge pclk);
        chk_all("rstwrap.release", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have port: pclk  input  1  pixel clock, 40 MHz, all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: en  input  1  count enable; low freezes all counters and outputs.
REQ-004 SHALL have port: hcount_out  output  12  horizontal pixel position, 0..1055.
REQ-005 SHALL have port: vcount_out  output  12  vertical line position, 0..627.
REQ-006 SHALL have port: hsync_out  output  1  horizontal sync, active-high.
REQ-007 SHALL have port: vsync_out  output  1  vertical sync, active-high.
REQ-008 SHALL have port: hblnk_out  output  1  horizontal blanking flag.
REQ-009 SHALL have port: vblnk_out  output  1  vertical blanking flag.
REQ-010 SHALL have port: frame_start  output  1  one-cycle pulse at position (0,0).
REQ-011 SHALL have port: frame_cnt  output  16  completed-frame counter.

Function
REQ-012 SHALL implement 800x600 at 60 Hz: H total 1056 (visible 800, front porch 40, sync 128, back porch 88); V total 628 (visible 600, front porch 1, sync 4, back porch 23).
REQ-013 SHALL register every output; no combinational path from any input to any output.
REQ-014 SHALL, on each rising edge with rst low and en high, advance hcount_out by 1, wrapping 1055 -> 0.
REQ-015 SHALL advance vcount_out by 1 only on the edge where hcount_out wraps 1055 -> 0, wrapping 627 -> 0 on the same edge.
REQ-016 SHALL drive hblnk_out high exactly when hcount_out is in 800..1055.
REQ-017 SHALL drive hsync_out high exactly when hcount_out is in 840..967.
REQ-018 SHALL drive vblnk_out high exactly when vcount_out is in 600..627.
REQ-019 SHALL drive vsync_out high exactly when vcount_out is in 601..604.
REQ-020 SHALL decode flags from next-state counter values, so flags and counts presented in the same cycle are always mutually consistent (zero relative latency).
REQ-021 SHALL drive frame_start high for exactly one cycle when the outputs transition to (hcount 0, vcount 0) from (1055, 627); it SHALL NOT pulse on reset release.
REQ-022 SHALL hold all outputs unchanged while en is low, except frame_start, which SHALL be 0.
REQ-023 SHALL, when en falls on the wrap cycle, produce no frame_start; the pulse occurs on the first enabled edge that performs the wrap.

Reset
REQ-024 SHALL, on any rising edge with rst high, set hcount_out=0, vcount_out=0, hsync_out=0, vsync_out=0, hblnk_out=0, vblnk_out=0, frame_start=0, frame_cnt=0, regardless of en.
REQ-025 SHALL give rst priority over en and over any wrap occurring on the same edge.
REQ-026 SHALL, on the first enabled edge after rst falls, output hcount_out=1, vcount_out=0.
REQ-027 SHALL, when rst is asserted mid-frame, restart timing from (0,0) with no partial-frame increment of frame_cnt.

Configuration
REQ-028 SHALL honour macro VGA_TIMING_FRAME_CNT_EN.
REQ-029 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, increment frame_cnt by 1 (modulo 65536, 65535 -> 0) on each edge that asserts frame_start.
REQ-030 SHALL, without VGA_TIMING_FRAME_CNT_EN, tie frame_cnt to constant 0 and synthesize no counter register; all other behaviour is unchanged and the port list is identical.

Verification
REQ-031 SHALL cover: rst high 3 cycles, then en=1 -> all outputs 0 during reset; first enabled edge hcount_out=1, vcount_out=0, all flags 0.
REQ-032 SHALL cover: run one line from reset -> hblnk_out rises at hcount 800, hsync_out high for hcount 840..967 (128 cycles), hcount wraps 1055 -> 0 with vcount 0 -> 1.
REQ-033 SHALL cover: run 2 full frames (2 x 663168 cycles) -> vblnk_out high for vcount 600..627, vsync_out high for 601..604 (4 x 1056 cycles), frame_start pulses exactly twice, one cycle wide, 663168 cycles apart.
REQ-034 SHALL cover: en low for 50 cycles at hcount 500, vcount 10 -> outputs hold 500/10, frame_start 0; counting resumes at 501.
REQ-035 SHALL cover: rst asserted at hcount 900, vcount 300 -> next edge all outputs 0, frame_cnt unchanged at 0.
REQ-036 SHALL cover: with VGA_TIMING_FRAME_CNT_EN, force frame_cnt to 65535 before wrap -> becomes 0 with frame_start; without the macro frame_cnt stays 0 throughout.
